// File: rtl/mem_wr_axi_d.sv
`default_nettype none
// ============================================================================
// Module      : mem_wr_axi_d
// Description : D-cache write-back engine. Issues one victim line (INCR burst)
//               or one uncached store as an AXI write, one transaction at a time.
//               Optional build macro WB_EARLY_W_EN overlaps AW and W phases.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wr_axi_d #(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_req,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [32*LINE_WORDS-1:0] wr_line,
    input  logic                     wr_uncache,
    input  logic [3:0]               wr_type,
    output logic                     wr_rdy,
    output logic                     wr_done,
    output logic [ADDR_WIDTH-1:0]    awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(LINE_WORDS - 1);
    localparam logic [7:0]       c_awlen     = 8'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
`ifdef WB_EARLY_W_EN
    localparam logic [1:0] S_AW_W = 2'd1;
`else
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
`endif
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [32*LINE_WORDS-1:0] r_line;
    logic [ADDR_WIDTH-1:0]    r_awaddr;
    logic [7:0]               r_awlen;
    logic [2:0]               r_awsize;
    logic                     r_awvalid;
    logic [31:0]              r_wdata;
    logic [3:0]               r_wstrb;
    logic                     r_wlast;
    logic                     r_wvalid;
    logic                     r_bready;
    logic                     r_done;
`ifdef WB_EARLY_W_EN
    logic                     r_aw_done;
    logic                     r_w_done;
    logic                     w_aw_ok;
    logic                     w_w_ok;
`endif

    logic [31:0]      w_words [LINE_WORDS];
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_beat;
    logic [31:0]      w_udata;
    logic [3:0]       w_ustrb;
    logic [2:0]       w_usize;
    logic             w_unused_bresp;

    generate
        for (genvar g = 0; g < LINE_WORDS; g++) begin : g_words
            assign w_words[g] = r_line[32*g +: 32];
        end
    endgenerate

    assign w_next_cnt     = r_cnt + 1'b1;
    assign w_beat         = r_wvalid & wready;
    // Uncached stores arrive unshifted; lane placement follows the low address bits.
    assign w_udata        = wr_line[31:0] << {wr_addr[1:0], 3'b000};
    assign w_ustrb        = wr_type << wr_addr[1:0];
    assign w_usize        = (wr_type == 4'b0001) ? 3'd0 :
                            (wr_type == 4'b0011) ? 3'd1 : 3'd2;
    assign w_unused_bresp = ^bresp;

`ifdef WB_EARLY_W_EN
    assign w_aw_ok = r_aw_done | (r_awvalid & awready);
    assign w_w_ok  = r_w_done  | (w_beat & r_wlast);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_line    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
`ifdef WB_EARLY_W_EN
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_req) begin
                        r_line    <= wr_line;
                        r_cnt     <= '0;
                        r_awaddr  <= wr_uncache ? wr_addr : {wr_addr[ADDR_WIDTH-1:6], 6'b0};
                        r_awlen   <= wr_uncache ? 8'd0 : c_awlen;
                        r_awsize  <= wr_uncache ? w_usize : 3'b010;
                        r_wdata   <= wr_uncache ? w_udata : wr_line[31:0];
                        r_wstrb   <= wr_uncache ? w_ustrb : 4'hF;
                        r_wlast   <= wr_uncache | (c_last_beat == '0);
                        r_awvalid <= 1'b1;
`ifdef WB_EARLY_W_EN
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_AW_W;
`else
                        r_state   <= S_AW;
`endif
                    end
                end
`ifdef WB_EARLY_W_EN
                S_AW_W: begin
                    if (r_awvalid && awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_beat && r_wlast) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // Both halves may finish in the same cycle.
                    if (w_aw_ok && w_w_ok) begin
                        r_bready  <= 1'b1;
                        r_cnt     <= '0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_B;
                    end
                end
`else
                S_AW: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (w_beat && r_wlast) begin
                        r_wvalid <= 1'b0;
                        r_bready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_B;
                    end
                end
`endif
                S_B: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Preload the next beat so W outputs stay registered.
            if (w_beat && !r_wlast) begin
                r_cnt   <= w_next_cnt;
                r_wdata <= w_words[w_next_cnt];
                r_wlast <= (w_next_cnt == c_last_beat);
            end
        end
    end

    assign wr_rdy  = (r_state == S_IDLE);
    assign wr_done = r_done;
    assign awaddr  = r_awaddr;
    assign awlen   = r_awlen;
    assign awsize  = r_awsize;
    assign awburst = 2'b01;
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = r_wlast;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_axi_d.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wr_axi_d
// Description : Directed self-checking bench for mem_wr_axi_d (both builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wr_axi_d;

    localparam int LW = 16;
    localparam int AW = 32;

`ifdef WB_EARLY_W_EN
    localparam int c_done_lat  = 18;
    localparam int c_first_lat = 1;
`else
    localparam int c_done_lat  = 19;
    localparam int c_first_lat = 2;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            wr_req = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [LW*32-1:0] wr_line = '0;
    logic            wr_uncache = 1'b0;
    logic [3:0]      wr_type = '0;
    logic            wr_rdy, wr_done;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready = 1'b1;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast, wvalid;
    logic            wready = 1'b1;
    logic [1:0]      bresp = 2'b00;
    logic            bvalid = 1'b1;
    logic            bready;

    mem_wr_axi_d #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .wr_req(wr_req), .wr_addr(wr_addr), .wr_line(wr_line),
        .wr_uncache(wr_uncache), .wr_type(wr_type), .wr_rdy(wr_rdy), .wr_done(wr_done),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake readies: fixed high, AW held low for aw_hold cycles, or random.
    bit rnd_mode = 1'b0;
    int aw_hold  = 0;
    always @(posedge clk) begin
        #1;
        if (rnd_mode) begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            bvalid  = 1'($urandom_range(0, 1));
            bresp   = 2'($urandom_range(0, 3));
        end else begin
            awready = (aw_hold == 0);
            if (aw_hold > 0) aw_hold--;
            wready = 1'b1;
            bvalid = 1'b1;
        end
    end

    // Bus monitor, sampled mid-cycle.
    logic [31:0] beat_data [64];
    logic [3:0]  beat_strb [64];
    logic        beat_last [64];
    int          beat_cyc  [64];
    int          beat_n = 0, aw_n = 0, done_n = 0;
    int          aw_cyc = 0, b_cyc = 0, done_cyc = 0;
    logic [AW-1:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    bit          txn_active = 1'b0;
    bit          aw_stall = 1'b0, w_stall = 1'b0;
    logic [AW-1:0] p_awaddr;
    logic [7:0]  p_awlen;
    logic [2:0]  p_awsize;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;
    logic        p_wlast;

    always @(negedge clk) begin
        if (!rstn) begin
            aw_stall = 1'b0;
            w_stall  = 1'b0;
        end else begin
            if (aw_stall)
                check_val("aw_stable", {awvalid, awaddr, awlen, awsize}, {1'b1, p_awaddr, p_awlen, p_awsize});
            if (w_stall)
                check_val("w_stable", {wvalid, wlast, wstrb, wdata}, {1'b1, p_wlast, p_wstrb, p_wdata});
`ifndef WB_EARLY_W_EN
            if (wvalid) check_val("w_before_aw", 64'(aw_n > 0), 64'd1);
`endif
            if (txn_active && !wr_done) check_val("rdy_busy", 64'(wr_rdy), 64'd0);
            if (awvalid && awready) begin
                m_awaddr = awaddr; m_awlen = awlen; m_awsize = awsize; m_awburst = awburst;
                aw_cyc = cyc;
                aw_n++;
            end
            if (wvalid && wready) begin
                beat_data[beat_n] = wdata;
                beat_strb[beat_n] = wstrb;
                beat_last[beat_n] = wlast;
                beat_cyc[beat_n]  = cyc;
                if (beat_n < 63) beat_n++;
            end
            if (bvalid && bready) b_cyc = cyc;
            if (wr_done) begin
                done_n++;
                done_cyc   = cyc;
                txn_active = 1'b0;
            end
            aw_stall = awvalid && !awready;
            w_stall  = wvalid && !wready;
            p_awaddr = awaddr; p_awlen = awlen; p_awsize = awsize;
            p_wdata  = wdata;  p_wstrb = wstrb; p_wlast  = wlast;
        end
    end

    int done_base = 0;

    task automatic do_req(input logic [AW-1:0] a, input logic [LW*32-1:0] l,
                          input logic unc, input logic [3:0] t, output int tq);
        @(posedge clk); #1;
        beat_n = 0; aw_n = 0; done_base = done_n;
        check_val("rdy_before_req", 64'(wr_rdy), 64'd1);
        wr_req = 1'b1; wr_addr = a; wr_line = l; wr_uncache = unc; wr_type = t;
        tq = cyc;
        @(posedge clk); #1;
        txn_active = 1'b1;
        wr_req = 1'b0; wr_addr = 32'hDEAD_0001; wr_line = ~l; wr_uncache = ~unc; wr_type = 4'h5;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_n > done_base) return;
        end
        check_val("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_line(input string tag, input logic [LW*32-1:0] l);
        check_val({tag, "_nbeats"}, 64'(beat_n), 64'(LW));
        for (int i = 0; i < LW; i++) begin
            check_val($sformatf("%s_wdata%0d", tag, i), beat_data[i], l[i*32 +: 32]);
            check_val($sformatf("%s_wstrb%0d", tag, i), beat_strb[i], 4'hF);
            check_val($sformatf("%s_wlast%0d", tag, i), beat_last[i], 64'(i == LW - 1));
        end
    endtask

    task automatic run_unc(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] t, input logic [31:0] exp_d,
                           input logic [3:0] exp_s, input logic [2:0] exp_sz);
        int tq;
        logic [LW*32-1:0] l;
        l = '0;
        l[31:0] = d;
        do_req(a, l, 1'b1, t, tq);
        wait_done();
        check_val({tag, "_aw"}, {m_awaddr, m_awlen, m_awsize, m_awburst}, {a, 8'd0, exp_sz, 2'b01});
        check_val({tag, "_nbeats"}, 64'(beat_n), 64'd1);
        check_val({tag, "_w"}, {beat_data[0], beat_strb[0], beat_last[0]}, {exp_d, exp_s, 1'b1});
    endtask

    logic [LW*32-1:0] line;
    int tq;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_valids", {awvalid, wvalid, bready, wlast, wr_done}, 5'b0);
        check_val("rst_rdy", 64'(wr_rdy), 64'd1);
        check_val("rst_aw", {awaddr, awlen, awsize, awburst}, {32'h0, 8'h0, 3'h0, 2'b01});
        check_val("rst_w", {wdata, wstrb}, 36'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // 1: cached line, all readies high
        for (int i = 0; i < LW; i++) line[i*32 +: 32] = 32'h1111_1111 * i;
        do_req(32'h1234_5678, line, 1'b0, 4'hF, tq);
        wait_done();
        check_val("t1_aw", {m_awaddr, m_awlen, m_awsize, m_awburst}, {32'h1234_5640, 8'd15, 3'd2, 2'b01});
        check_val("t1_aw_cyc", 64'(aw_cyc - tq), 64'd1);
        check_val("t1_first_beat_cyc", 64'(beat_cyc[0] - tq), 64'(c_first_lat));
        check_val("t1_done_lat", 64'(done_cyc - tq), 64'(c_done_lat));
        check_line("t1", line);
        @(negedge clk);
        check_val("t1_rdy_after", 64'(wr_rdy), 64'd1);
        repeat (3) @(negedge clk);
        check_val("t1_single_done", 64'(done_n - done_base), 64'd1);

        // 2, 3: uncached stores (plus an aligned word)
        run_unc("t2_byte", 32'hBFD0_0003, 32'h0000_00AB, 4'b0001, 32'hAB00_0000, 4'b1000, 3'd0);
        run_unc("t3_half", 32'h8000_0002, 32'h0000_BEEF, 4'b0011, 32'hBEEF_0000, 4'b1100, 3'd1);
        run_unc("t3_word", 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 4'b1111, 3'd2);

        // 4: random backpressure
        rnd_mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < LW; i++) line[i*32 +: 32] = $urandom;
            do_req(32'h0040_0000 + 32'(k * 64) + 32'h0C, line, 1'b0, 4'hF, tq);
            wait_done();
            check_val($sformatf("t4_awaddr%0d", k), m_awaddr, 32'h0040_0000 + 32'(k * 64));
            check_line($sformatf("t4_%0d", k), line);
        end
        run_unc("t4_byte", 32'h2000_0001, 32'h0000_005A, 4'b0001, 32'h0000_5A00, 4'b0010, 3'd0);
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk);

        // 5: asynchronous reset mid-burst
        for (int i = 0; i < LW; i++) line[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
        do_req(32'h0000_1000, line, 1'b0, 4'hF, tq);
        for (int i = 0; i < 100 && beat_n < 7; i++) @(negedge clk);
        check_val("t5_reached_beat7", 64'(beat_n >= 7), 64'd1);
        txn_active = 1'b0;
        rstn = 1'b0;
        #1;
        check_val("t5_valids_off", {awvalid, wvalid, bready, wr_done}, 4'b0);
        check_val("t5_rdy", 64'(wr_rdy), 64'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (25) @(negedge clk);
        check_val("t5_no_done", 64'(done_n - done_base), 64'd0);
        for (int i = 0; i < LW; i++) line[i*32 +: 32] = 32'h5A5A_0000 + 32'(i);
        do_req(32'h0000_2000, line, 1'b0, 4'hF, tq);
        wait_done();
        check_line("t5_restart", line);

`ifdef WB_EARLY_W_EN
        // 6: W runs ahead of a stalled AW
        @(negedge clk);
        aw_hold = 20;
        for (int i = 0; i < LW; i++) line[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        do_req(32'h0000_3000, line, 1'b0, 4'hF, tq);
        wait_done();
        check_line("t6", line);
        check_val("t6_w_before_aw", 64'(beat_cyc[LW-1] < aw_cyc), 64'd1);
        check_val("t6_b_after_aw", 64'(b_cyc - aw_cyc), 64'd1);
        check_val("t6_done_after_b", 64'(done_cyc - b_cyc), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
